// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
// Address layout: tag = addr[7:4], line index = addr[3:2], byte offset = addr[1:0].
package dcache_pkg;

   localparam int TAG_W         = 4;
   localparam int IDX_W         = 2;
   localparam int OFF_W         = 2;
   localparam int AW            = TAG_W + IDX_W + OFF_W;
   localparam int REFILL_CYCLES = 5;

   typedef enum logic {
      IDLE,
      REFILL
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [AW-1:0] addr);
      return addr[AW-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] addr);
      return addr[OFF_W +: IDX_W];
   endfunction

   function automatic logic [OFF_W-1:0] addr_off(input logic [AW-1:0] addr);
      return addr[OFF_W-1:0];
   endfunction

   function automatic logic [AW-1:0] line_base(input logic [AW-1:0] addr);
      return {addr[AW-1:OFF_W], {OFF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational lookup port, synchronous byte write
// port and a tag/valid write port. Only the valid bits are reset.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int NUM_LINES  = 4,
   parameter int LINE_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [TAG_W-1:0]  rd_tag,
   input  logic [OFF_W-1:0]  rd_off,
   output logic              rd_hit,
   output logic [DATA_W-1:0] rd_data,
   input  logic              byte_we,
   input  logic [IDX_W-1:0]  byte_idx,
   input  logic [OFF_W-1:0]  byte_off,
   input  logic [DATA_W-1:0] byte_data,
   input  logic              tag_we,
   input  logic [IDX_W-1:0]  tag_idx,
   input  logic [TAG_W-1:0]  tag_val,
   input  logic              tag_valid
);

   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tags [NUM_LINES];
   logic [DATA_W-1:0]    data [NUM_LINES][LINE_WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (tag_we) begin
         valid[tag_idx] <= tag_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we) begin
         tags[tag_idx] <= tag_val;
      end
      if (byte_we) begin
         data[byte_idx][byte_off] <= byte_data;
      end
   end

   assign rd_hit  = valid[rd_idx] && (tags[rd_idx] == rd_tag);
   assign rd_data = data[rd_idx][rd_off];

endmodule

// File: rtl/dcache_controller.sv
// Write-through, no-write-allocate direct-mapped data cache controller with
// a 4-word read-miss refill sequencer and saturating hit/miss statistics.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int NUM_LINES  = 4,
   parameter int LINE_WORDS = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_read,
   input  logic              cpu_write,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   state_t            state, state_next;
   logic [ADDR_W-1:0] base_addr;
   logic [2:0]        issue_cnt, recv_cnt;
   logic              refill_done;
   logic              refill_finish, miss_start, count_hit, issuing, capturing;
   logic [CNT_W-1:0]  hit_q, miss_q;

   logic              lookup_hit;
   logic [DATA_W-1:0] lookup_data;
   logic              byte_we, tag_we, tag_valid;
   logic [IDX_W-1:0]  byte_idx, tag_idx;
   logic [OFF_W-1:0]  byte_off;
   logic [DATA_W-1:0] byte_data;
   logic [TAG_W-1:0]  tag_val;

   dcache_array #(
      .DATA_W     (DATA_W),
      .NUM_LINES  (NUM_LINES),
      .LINE_WORDS (LINE_WORDS)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (addr_idx(cpu_addr)),
      .rd_tag    (addr_tag(cpu_addr)),
      .rd_off    (addr_off(cpu_addr)),
      .rd_hit    (lookup_hit),
      .rd_data   (lookup_data),
      .byte_we   (byte_we),
      .byte_idx  (byte_idx),
      .byte_off  (byte_off),
      .byte_data (byte_data),
      .tag_we    (tag_we),
      .tag_idx   (tag_idx),
      .tag_val   (tag_val),
      .tag_valid (tag_valid)
   );

   // Outputs are gated by rst_n so an asserted reset silences the storage bus at once.
   always_comb begin
      state_next    = state;
      cpu_rdata     = '0;
      cpu_stall     = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      refill_finish = 1'b0;
      miss_start    = 1'b0;
      count_hit     = 1'b0;
      issuing       = 1'b0;
      capturing     = 1'b0;
      byte_we       = 1'b0;
      byte_idx      = addr_idx(cpu_addr);
      byte_off      = addr_off(cpu_addr);
      byte_data     = cpu_wdata;
      tag_we        = 1'b0;
      tag_idx       = addr_idx(cpu_addr);
      tag_val       = addr_tag(cpu_addr);
      tag_valid     = 1'b0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (cpu_write) begin
                  mem_write = 1'b1;
                  mem_addr  = cpu_addr;
                  mem_wdata = cpu_wdata;
                  byte_we   = lookup_hit;
               end else if (cpu_read) begin
                  if (lookup_hit) begin
                     cpu_rdata = lookup_data;
                     count_hit = !refill_done;
                  end else begin
                     // Invalidate the victim line up front so a reset mid-refill leaves it invalid.
                     cpu_stall  = 1'b1;
                     miss_start = 1'b1;
                     tag_we     = 1'b1;
                     state_next = REFILL;
                  end
               end
            end
            REFILL: begin
               cpu_stall = 1'b1;
               byte_idx  = addr_idx(base_addr);
               byte_off  = recv_cnt[OFF_W-1:0];
               byte_data = mem_rdata;
               tag_idx   = addr_idx(base_addr);
               tag_val   = addr_tag(base_addr);
               if (issue_cnt < 3'(REFILL_CYCLES - 1)) begin
                  issuing  = 1'b1;
                  mem_read = 1'b1;
                  mem_addr = base_addr + ADDR_W'(issue_cnt);
               end
               // Storage answers one cycle after each issue, so receive trails issue by one.
               if (recv_cnt < issue_cnt) begin
                  capturing = 1'b1;
                  byte_we   = 1'b1;
                  if (recv_cnt == 3'(LINE_WORDS - 1)) begin
                     tag_we        = 1'b1;
                     tag_valid     = 1'b1;
                     refill_finish = 1'b1;
                     state_next    = IDLE;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         base_addr   <= '0;
         issue_cnt   <= '0;
         recv_cnt    <= '0;
         refill_done <= 1'b0;
         hit_q       <= '0;
         miss_q      <= '0;
      end else begin
         state       <= state_next;
         refill_done <= refill_finish;
         if (miss_start) begin
            base_addr <= ADDR_W'(line_base(cpu_addr));
            issue_cnt <= '0;
            recv_cnt  <= '0;
         end else begin
            if (issuing) begin
               issue_cnt <= issue_cnt + 3'd1;
            end
            if (capturing) begin
               recv_cnt <= recv_cnt + 3'd1;
            end
         end
         if (count_hit && (hit_q != '1)) begin
            hit_q <= hit_q + 1'b1;
         end
         if (miss_start && (miss_q != '1)) begin
            miss_q <= miss_q + 1'b1;
         end
      end
   end

   assign hit_cnt  = hit_q;
   assign miss_cnt = miss_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized self-checking bench for dcache_controller: a transaction-level
// cache/storage model predicts every output each cycle, plus directed literal checks.
module tb_dcache_controller;

   logic        clk;
   logic        rst_n;
   logic [7:0]  cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_read;
   logic        cpu_write;
   logic [7:0]  cpu_rdata;
   logic        cpu_stall;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [7:0]  mem_rdata;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int checks = 0;
   int passed = 0;

   dcache_controller dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_read  (cpu_read),
      .cpu_write (cpu_write),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing storage driven by the DUT: one-cycle read latency.
   logic [7:0] storage [256];
   always @(posedge clk) begin
      if (mem_write) storage[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= storage[mem_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
   endtask

   // Reference model: abstract cache contents, miss progress and statistics.
   logic [7:0]  ref_mem [256];
   logic        m_valid [4];
   logic [3:0]  m_tag   [4];
   logic [7:0]  m_data  [4][4];
   logic [7:0]  m_base;
   int          m_phase;
   logic        m_tail;
   logic [15:0] m_hits, m_misses;
   logic        e_stall, e_mr, e_mw, m_hit;
   logic [7:0]  e_rdata, e_addr, e_wdata;
   logic [1:0]  li;

   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("rst_stall", 32'(cpu_stall), 32'd0);
         checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
         checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
         checkOutput("rst_rdata", 32'(cpu_rdata), 32'd0);
         checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
         checkOutput("rst_counters", {hit_cnt, miss_cnt}, 32'd0);
         for (int k = 0; k < 4; k++) m_valid[k] = 1'b0;
         m_phase  = 0;
         m_tail   = 1'b0;
         m_hits   = 16'd0;
         m_misses = 16'd0;
      end else begin
         e_stall = 1'b0; e_mr = 1'b0; e_mw = 1'b0;
         e_rdata = 8'd0; e_addr = 8'd0; e_wdata = 8'd0;
         m_hit = m_valid[cpu_addr[3:2]] && (m_tag[cpu_addr[3:2]] == cpu_addr[7:4]);
         if (m_phase == 0) begin
            if (cpu_write) begin
               e_mw = 1'b1; e_addr = cpu_addr; e_wdata = cpu_wdata;
            end else if (cpu_read) begin
               if (m_hit) e_rdata = m_data[cpu_addr[3:2]][cpu_addr[1:0]];
               else       e_stall = 1'b1;
            end
         end else begin
            e_stall = 1'b1;
            if (m_phase <= 4) begin
               e_mr   = 1'b1;
               e_addr = m_base + 8'(m_phase - 1);
            end
         end
         checkOutput("cpu_stall", 32'(cpu_stall), 32'(e_stall));
         checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
         checkOutput("mem_read", 32'(mem_read), 32'(e_mr));
         checkOutput("mem_write", 32'(mem_write), 32'(e_mw));
         checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
         checkOutput("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
         checkOutput("hit_cnt", 32'(hit_cnt), 32'(m_hits));
         checkOutput("miss_cnt", 32'(miss_cnt), 32'(m_misses));
         // Advance the model to what holds after the coming rising edge.
         if (m_phase == 0) begin
            if (cpu_write) begin
               ref_mem[cpu_addr] = cpu_wdata;
               if (m_hit) m_data[cpu_addr[3:2]][cpu_addr[1:0]] = cpu_wdata;
            end else if (cpu_read) begin
               if (m_hit) begin
                  if (!m_tail && m_hits != 16'hFFFF) m_hits = m_hits + 16'd1;
               end else begin
                  m_base  = {cpu_addr[7:2], 2'b00};
                  m_valid[cpu_addr[3:2]] = 1'b0;
                  m_phase = 1;
                  if (m_misses != 16'hFFFF) m_misses = m_misses + 16'd1;
               end
            end
            m_tail = 1'b0;
         end else if (m_phase == 5) begin
            li = m_base[3:2];
            for (int w = 0; w < 4; w++) m_data[li][w] = ref_mem[m_base + 8'(w)];
            m_tag[li]   = m_base[7:4];
            m_valid[li] = 1'b1;
            m_tail      = 1'b1;
            m_phase     = 0;
         end else begin
            m_phase = m_phase + 1;
         end
      end
   end

   // Drives one request (called just after a rising edge) and holds it until the stall clears.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr,
                                input logic [7:0] wdata, output logic [7:0] rdata,
                                output int stalls, output logic [31:0] seen_rd,
                                output logic [15:0] seen_wr);
      cpu_read  = rd;
      cpu_write = wr;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      stalls    = 0;
      rdata     = 8'd0;
      seen_rd   = 32'd0;
      seen_wr   = 16'd0;
      forever begin
         @(negedge clk);
         if (mem_read) seen_rd = {seen_rd[23:0], mem_addr};
         if (!cpu_stall) begin
            rdata = cpu_rdata;
            if (mem_write) seen_wr = {mem_addr, mem_wdata};
            break;
         end
         stalls++;
         if (stalls > 20) begin
            checkOutput("stall_timeout", 32'(stalls), 32'd6);
            break;
         end
      end
      @(posedge clk);
      #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   logic [7:0]  rd;
   int          st;
   logic [31:0] srd;
   logic [15:0] swr;
   logic [15:0] miss_before;
   int          op;
   logic [7:0]  ra;

   initial begin
      rst_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 8'd0; cpu_wdata = 8'd0;
      for (int a = 0; a < 256; a++) begin
         storage[a] = 8'($urandom);
         ref_mem[a] = storage[a];
      end
      storage[8'h24] = 8'h11; storage[8'h25] = 8'h22; storage[8'h26] = 8'h33; storage[8'h27] = 8'h44;
      for (int a = 8'h24; a < 8'h28; a++) ref_mem[a] = storage[a];
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Read miss with full refill, then a same-line hit.
      applyStimulus(1'b1, 1'b0, 8'h25, 8'h00, rd, st, srd, swr);
      checkOutput("t1_rdata", 32'(rd), 32'h22);
      checkOutput("t1_stalls", 32'(st), 32'd6);
      checkOutput("t1_refill_addrs", srd, 32'h24252627);
      checkOutput("t1_miss_cnt", 32'(miss_cnt), 32'd1);
      checkOutput("t1_hit_cnt", 32'(hit_cnt), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'h27, 8'h00, rd, st, srd, swr);
      checkOutput("t2_rdata", 32'(rd), 32'h44);
      checkOutput("t2_stalls", 32'(st), 32'd0);
      checkOutput("t2_no_mem_read", srd, 32'd0);
      checkOutput("t2_hit_cnt", 32'(hit_cnt), 32'd1);

      // Write hit updates both storage and the cached byte.
      applyStimulus(1'b0, 1'b1, 8'h26, 8'hAB, rd, st, srd, swr);
      checkOutput("t3_write_bus", 32'(swr), 32'h26AB);
      checkOutput("t3_stalls", 32'(st), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'h26, 8'h00, rd, st, srd, swr);
      checkOutput("t3_read_back", 32'(rd), 32'hAB);

      // Write miss does not allocate; the following read refills it.
      applyStimulus(1'b0, 1'b1, 8'h80, 8'h5A, rd, st, srd, swr);
      checkOutput("t4_write_bus", 32'(swr), 32'h805A);
      applyStimulus(1'b1, 1'b0, 8'h80, 8'h00, rd, st, srd, swr);
      checkOutput("t4_stalls", 32'(st), 32'd6);
      checkOutput("t4_rdata", 32'(rd), 32'h5A);
      checkOutput("t4_miss_cnt", 32'(miss_cnt), 32'd2);

      // Conflicting lines on index 1 evict each other.
      miss_before = miss_cnt;
      applyStimulus(1'b1, 1'b0, 8'h05, 8'h00, rd, st, srd, swr);
      applyStimulus(1'b1, 1'b0, 8'h45, 8'h00, rd, st, srd, swr);
      applyStimulus(1'b1, 1'b0, 8'h05, 8'h00, rd, st, srd, swr);
      checkOutput("t5_conflict_misses", 32'(miss_cnt - miss_before), 32'd3);

      // Reset in the middle of a refill, then the same read refills from scratch.
      cpu_read = 1'b1; cpu_addr = 8'h25;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("t6_mem_read", 32'(mem_read), 32'd0);
      checkOutput("t6_stall", 32'(cpu_stall), 32'd0);
      checkOutput("t6_counters", {hit_cnt, miss_cnt}, 32'd0);
      cpu_read = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'h25, 8'h00, rd, st, srd, swr);
      checkOutput("t6_stalls", 32'(st), 32'd6);
      checkOutput("t6_rdata", 32'(rd), 32'h22);
      checkOutput("t6_refill_addrs", srd, 32'h24252627);

      // Random mix of reads, writes, simultaneous requests and idle cycles.
      for (int n = 0; n < 300; n++) begin
         op = int'($urandom_range(0, 9));
         ra = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
         if (op < 2) begin
            @(posedge clk);
            #1;
         end else if (op < 5) begin
            applyStimulus(1'b0, 1'b1, ra, 8'($urandom), rd, st, srd, swr);
         end else begin
            applyStimulus(1'b1, $urandom_range(0, 7) == 0, ra, 8'($urandom), rd, st, srd, swr);
         end
      end

      @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
